mpmc10_req_fifo256_wb: RTL and testbench

- Synchronous first-word-fall-through FIFO for 256-bit Wishbone write requests.
- Sits directly upstream of the 256-bit request sync register that feeds the mpmc10 port arbiter.
- Absorbs write bursts from a client while the controller is busy, and presents the oldest request at its output.
- Provides full/almost-full back-pressure and single-cycle error pulses.

---
 rtl/mpmc10_pkg.sv | 16 +
 rtl/mpmc10_req_fifo_ram.sv | 22 ++
 rtl/mpmc10_req_fifo256_wb.sv | 81 ++++++++
 tb/tb_mpmc10_req_fifo256_wb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mpmc10_pkg.sv
// Shared mpmc10 types and instantiation defaults.
package mpmc10_pkg;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [31:0]  sel;
    logic [31:0]  adr;
    logic [255:0] dat;
  } wb_write_request256_t;

  localparam int MPMC10_REQ_FIFO_DEPTH = 16;
  localparam int MPMC10_REQ_FIFO_AFULL = 12;

endpackage

// File: rtl/mpmc10_req_fifo_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module mpmc10_req_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/mpmc10_req_fifo256_wb.sv
// First-word-fall-through FIFO for 256-bit Wishbone write requests with
// registered head output, occupancy flags and overflow/underflow pulses.
module mpmc10_req_fifo256_wb
  import mpmc10_pkg::*;
#(
  parameter int DEPTH     = MPMC10_REQ_FIFO_DEPTH,
  parameter int AFULL_LVL = MPMC10_REQ_FIFO_AFULL,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  wb_write_request256_t i,
  input  logic                 rd,
  output wb_write_request256_t o,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [AW:0]          count,
  output logic                 ovf,
  output logic                 unf
);

  localparam int W = $bits(wb_write_request256_t);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [AW:0]   count_n;
  logic          push, pop;
  logic [W-1:0]  ram_q;
  wb_write_request256_t head_n;

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign pop  = rd & ~empty;
  assign push = wr & (~full | pop);

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
    rptr_n = pop ? rptr + 1'b1 : rptr;
    // The RAM read is asynchronous, so a head entry being written this
    // very edge has to be taken straight from the input.
    head_n = (push && wptr == rptr_n) ? i : wb_write_request256_t'(ram_q);
  end

  mpmc10_req_fifo_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (i),
    .raddr (rptr_n),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      o           <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      rptr        <= rptr_n;
      count       <= count_n;
      empty       <= (count_n == '0);
      full        <= (count_n == FULL_CNT);
      almost_full <= (count_n >= AFULL_CNT);
      ovf         <= wr & ~push;
      unf         <= rd & empty;
      if (count_n != '0) o <= head_n;
    end
  end

endmodule

// File: tb/tb_mpmc10_req_fifo256_wb.sv
// Self-checking bench: directed scenarios plus random traffic vs a queue model.
module tb_mpmc10_req_fifo256_wb;
  import mpmc10_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst, wr, rd;
  wb_write_request256_t i, o;
  logic empty, full, almost_full, ovf, unf;
  logic [AW:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  wb_write_request256_t q[$];
  wb_write_request256_t m_o;
  logic m_ovf, m_unf;

  always #5 clk = ~clk;

  mpmc10_req_fifo256_wb #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .rst(rst), .wr(wr), .i(i), .rd(rd), .o(o),
    .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic wb_write_request256_t mk(input logic [31:0] adr);
    wb_write_request256_t r;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    r.we  = 1'b1;
    r.sel = $urandom;
    r.adr = adr;
    r.dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // One clock: apply inputs, advance model at the edge, check on the falling edge.
  task automatic step(input logic r, input logic w, input logic p, input wb_write_request256_t d);
    int n;
    logic push_ok, pop_ok;
    rst = r; wr = w; rd = p; i = d;
    @(posedge clk);
    n = q.size();
    if (r) begin
      q.delete();
      m_o = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      pop_ok  = p && n > 0;
      push_ok = w && (n < DEPTH || pop_ok);
      m_ovf = w && !push_ok;
      m_unf = p && n == 0;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(d);
      if (q.size() > 0) m_o = q[0];
    end
    @(negedge clk);
    chk("o",           512'(o),           512'(m_o));
    chk("count",       512'(count),       512'(q.size()));
    chk("empty",       512'(empty),       512'(q.size() == 0));
    chk("full",        512'(full),        512'(q.size() == DEPTH));
    chk("almost_full", 512'(almost_full), 512'(q.size() >= AFULL));
    chk("ovf",         512'(ovf),         512'(m_ovf));
    chk("unf",         512'(unf),         512'(m_unf));
  endtask

  initial begin
    wb_write_request256_t z, a;
    z = '0;
    m_o = '0; m_ovf = 1'b0; m_unf = 1'b0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; i = '0;
    @(negedge clk);
    step(1, 0, 0, z);
    for (int k = 0; k < 5; k++) step(0, 0, 0, z);

    // Single request in and out
    a = '0;
    a.cyc = 1'b1; a.stb = 1'b1; a.we = 1'b1;
    a.adr = 32'h0000_1000; a.sel = 32'hFFFF_FFFF; a.dat = {32{8'hA5}};
    step(0, 1, 0, a);
    chk("single_o", 512'(o), 512'(a));
    step(0, 0, 1, z);
    chk("single_empty", 512'(empty), 512'(1));

    // Fill, overflow, drain in order
    for (int k = 0; k < 16; k++) step(0, 1, 0, mk(32'(k * 16)));
    step(0, 1, 0, mk(32'h100));
    chk("ovf_pulse", 512'(ovf), 512'(1));
    step(0, 0, 0, z);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, z);
      if (k < 15) chk("drain_adr", 512'(o.adr), 512'((k + 1) * 16));
    end

    // Full with simultaneous push/pop across pointer wrap
    for (int k = 0; k < 16; k++) step(0, 1, 0, mk(32'(k)));
    for (int k = 0; k < 20; k++) step(0, 1, 1, mk(32'(16 + k)));
    chk("wrap_head", 512'(o.adr), 512'(20));
    for (int k = 0; k < 16; k++) step(0, 0, 1, z);

    // Underflow, with and without a simultaneous push
    step(0, 0, 1, z);
    chk("unf_pulse", 512'(unf), 512'(1));
    a = mk(32'hBEEF);
    step(0, 1, 1, a);
    chk("unf_push_o", 512'(o), 512'(a));
    step(0, 0, 1, z);

    // Reset mid-fill with a push on the reset edge
    for (int k = 0; k < 10; k++) step(0, 1, 0, mk(32'(k)));
    step(1, 1, 0, mk(32'hDEAD));
    chk("rst_count", 512'(count), 512'(0));
    step(0, 0, 0, z);

    // Random traffic in phases with different push/pop bias
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = 20 + 15 * ph;
      rp = 95 - 15 * ph;
      for (int k = 0; k < 100; k++)
        step($urandom_range(99) == 0, $urandom_range(99) < wp,
             $urandom_range(99) < rp, mk($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
